pix_stream_packer: RTL and testbench

- Parametrised successor to the fixed 32-bit RGB/raw stream packer.
- Packs raw (1-channel) or NUM_CHAN-channel pixels LSB-first into OUT_WIDTH-bit stream words.
- Packs 16-bit header words into stream words, substituting image_type into the header.
- New behaviour: zero-padded flush of partial words at frame end and at header end, a busy back-pressure signal, and a sticky overflow flag.
- Sits between the colour pipeline output and the host stream/USB FIFO.

---
 rtl/pix_stream_packer.sv | 244 ++++++++++++++++++++++++
 tb/tb_pix_stream_packer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pix_stream_packer.sv
// Packs raw or multi-channel pixels and 16-bit header words LSB-first into OUT_WIDTH-bit stream words.
// Latency: 1 cycle input to output; an event that forces a zero-padded flush appears 2 cycles after its input.
// Backpressure: busy is high for the flush cycle; dvi during busy is dropped and sets sticky overflow.
module pix_stream_packer #(
    parameter int PIXEL_WIDTH     = 10,
    parameter int NUM_CHAN        = 3,
    parameter int OUT_WIDTH       = 32,
    parameter int RAW_PIXEL_SHIFT = 0,
    parameter int DTYPE_WIDTH     = 4,
    // Data type encodings shared with the rest of the stream path
    parameter logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK   = 4'h8,
    parameter logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START  = 4'h1,
    parameter logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END    = 4'h2,
    parameter logic [DTYPE_WIDTH-1:0] DTYPE_HEADER_START = 4'h3,
    parameter logic [DTYPE_WIDTH-1:0] DTYPE_HEADER       = 4'h4,
    // Header word index that carries the image type
    parameter int IMAGE_TYPE_IDX = 2
) (
    input  logic                            clk,
    input  logic                            resetb,
    input  logic [15:0]                     image_type,
    input  logic                            dvi,
    input  logic [DTYPE_WIDTH-1:0]          dtypei,
    input  logic [15:0]                     meta_datai,
    input  logic [NUM_CHAN*PIXEL_WIDTH-1:0] pix,
    output logic                            dvo,
    output logic [DTYPE_WIDTH-1:0]          dtypeo,
    output logic [OUT_WIDTH-1:0]            datao,
    output logic                            busy,
    output logic                            overflow
);

    localparam int CW     = NUM_CHAN * PIXEL_WIDTH;
    localparam int BUF_W  = OUT_WIDTH + CW;
    localparam int POS_W  = $clog2(2 * OUT_WIDTH);
    localparam int SLOTS  = OUT_WIDTH / 16;
    localparam int SLOT_W = $clog2(SLOTS);

    localparam logic [POS_W-1:0]  OW_P     = POS_W'(OUT_WIDTH);
    localparam logic [POS_W-1:0]  RAW_W_P  = POS_W'(PIXEL_WIDTH);
    localparam logic [POS_W-1:0]  COL_W_P  = POS_W'(CW);
    localparam logic [CW-1:0]     RAW_MASK = CW'({PIXEL_WIDTH{1'b1}});
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);
    localparam logic [15:0]       IMG_IDX  = 16'(IMAGE_TYPE_IDX);

    if (OUT_WIDTH != 32 && OUT_WIDTH != 64) begin : g_bad_ow
        $error("pix_stream_packer: OUT_WIDTH must be 32 or 64");
    end
    if (CW > OUT_WIDTH) begin : g_bad_cw
        $error("pix_stream_packer: NUM_CHAN*PIXEL_WIDTH must not exceed OUT_WIDTH");
    end

    // Packing state
    logic [BUF_W-1:0]       buf_q, buf_d;
    logic [POS_W-1:0]       pos_q, pos_d;
    logic [OUT_WIDTH-1:0]   hbuf_q, hbuf_d;
    logic [15:0]            hidx_q, hidx_d;
    logic [DTYPE_WIDTH-1:0] sav_dtype_q, sav_dtype_d;

    // Event held back while its flush word is on the output
    logic                   pend_q, pend_d;
    logic [DTYPE_WIDTH-1:0] ev_dtype_q, ev_dtype_d;
    logic [15:0]            ev_meta_q, ev_meta_d;
    logic [CW-1:0]          ev_pix_q, ev_pix_d;

    // Registered outputs
    logic                   dvo_q, dvo_d;
    logic [DTYPE_WIDTH-1:0] dtypeo_q, dtypeo_d;
    logic [OUT_WIDTH-1:0]   datao_q, datao_d;
    logic                   ovf_q, ovf_d;

    // Working signals for the event being processed this cycle
    logic                   src_vld;
    logic [DTYPE_WIDTH-1:0] src_dtype;
    logic [15:0]            src_meta;
    logic [CW-1:0]          src_pix;
    logic                   is_pix, is_fs, is_fe, is_hs, is_hdr;
    logic                   flush_hdr, flush_pix;
    logic [CW-1:0]          pix_val;
    logic [POS_W-1:0]       pix_w;
    logic [POS_W-1:0]       pos_sum;
    logic [BUF_W-1:0]       packed_buf;
    logic [15:0]            hdr_word;
    logic [OUT_WIDTH-1:0]   hbuf_ins;

    // Next-state: pick the replayed event when one is pending, then pack/flush it
    always_comb begin
        buf_d       = buf_q;
        pos_d       = pos_q;
        hbuf_d      = hbuf_q;
        hidx_d      = hidx_q;
        sav_dtype_d = sav_dtype_q;
        pend_d      = 1'b0;
        ev_dtype_d  = ev_dtype_q;
        ev_meta_d   = ev_meta_q;
        ev_pix_d    = ev_pix_q;
        dvo_d       = 1'b0;
        dtypeo_d    = dtypei;
        datao_d     = '0;
        ovf_d       = ovf_q;

        // While busy the live input is ignored and the held event is replayed
        if (pend_q) begin
            src_vld   = 1'b1;
            src_dtype = ev_dtype_q;
            src_meta  = ev_meta_q;
            src_pix   = ev_pix_q;
        end else begin
            src_vld   = dvi;
            src_dtype = dtypei;
            src_meta  = meta_datai;
            src_pix   = pix;
        end

        is_pix = (src_dtype & DTYPE_PIXEL_MASK) != '0;
        is_fs  = !is_pix && (src_dtype == DTYPE_FRAME_START);
        is_fe  = !is_pix && (src_dtype == DTYPE_FRAME_END);
        is_hs  = !is_pix && (src_dtype == DTYPE_HEADER_START);
        is_hdr = !is_pix && (src_dtype == DTYPE_HEADER);

        // A partial header is closed by any non-header event; a partial pixel word only by frame end
        flush_hdr = src_vld && !is_hdr && (hidx_q[SLOT_W-1:0] != '0);
        flush_pix = src_vld && is_fe && (pos_q != '0) && !flush_hdr;

        if (image_type == 16'h0000) begin
            pix_val = CW'({{CW{1'b0}}, src_meta} >> RAW_PIXEL_SHIFT) & RAW_MASK;
            pix_w   = RAW_W_P;
        end else begin
            pix_val = src_pix;
            pix_w   = COL_W_P;
        end
        pos_sum    = pos_q + pix_w;
        packed_buf = buf_q | ({{OUT_WIDTH{1'b0}}, pix_val} << pos_q);

        hdr_word = (hidx_q == IMG_IDX) ? image_type : src_meta;
        hbuf_ins = hbuf_q;
        hbuf_ins[{hidx_q[SLOT_W-1:0], 4'b0000} +: 16] = hdr_word;

        if (src_vld) begin
            if (flush_hdr) begin
                dvo_d      = 1'b1;
                datao_d    = hbuf_q;
                dtypeo_d   = DTYPE_HEADER;
                hbuf_d     = '0;
                hidx_d     = '0;
                pend_d     = 1'b1;
                ev_dtype_d = src_dtype;
                ev_meta_d  = src_meta;
                ev_pix_d   = src_pix;
            end else if (flush_pix) begin
                dvo_d      = 1'b1;
                datao_d    = buf_q[OUT_WIDTH-1:0];
                dtypeo_d   = sav_dtype_q;
                buf_d      = '0;
                pos_d      = '0;
                pend_d     = 1'b1;
                ev_dtype_d = src_dtype;
                ev_meta_d  = src_meta;
                ev_pix_d   = src_pix;
            end else if (is_pix) begin
                dtypeo_d    = src_dtype;
                sav_dtype_d = src_dtype;
                if (pos_sum >= OW_P) begin
                    dvo_d   = 1'b1;
                    datao_d = packed_buf[OUT_WIDTH-1:0];
                    buf_d   = packed_buf >> OUT_WIDTH;
                    pos_d   = pos_sum - OW_P;
                end else begin
                    buf_d   = packed_buf;
                    pos_d   = pos_sum;
                end
            end else if (is_fs || is_hs) begin
                dvo_d    = 1'b1;
                dtypeo_d = src_dtype;
                buf_d    = '0;
                pos_d    = '0;
                hbuf_d   = '0;
                hidx_d   = '0;
                if (is_fs) begin
                    ovf_d = 1'b0;
                end
            end else if (is_hdr) begin
                dtypeo_d = src_dtype;
                hidx_d   = hidx_q + 16'd1;
                if (hidx_q[SLOT_W-1:0] == LAST_SLOT) begin
                    dvo_d   = 1'b1;
                    datao_d = hbuf_ins;
                    hbuf_d  = '0;
                end else begin
                    hbuf_d  = hbuf_ins;
                end
            end else begin
                // Frame end with no residual, or any other marker: pass through with zero data
                dvo_d    = 1'b1;
                dtypeo_d = src_dtype;
            end
        end

        // A dropped input during busy wins over a clearing frame start being replayed
        if (pend_q && dvi) begin
            ovf_d = 1'b1;
        end
    end

    // State and output registers, cleared asynchronously so a partial word is discarded
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            buf_q       <= '0;
            pos_q       <= '0;
            hbuf_q      <= '0;
            hidx_q      <= '0;
            sav_dtype_q <= '0;
            pend_q      <= 1'b0;
            ev_dtype_q  <= '0;
            ev_meta_q   <= '0;
            ev_pix_q    <= '0;
            dvo_q       <= 1'b0;
            dtypeo_q    <= '0;
            datao_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            pos_q       <= pos_d;
            hbuf_q      <= hbuf_d;
            hidx_q      <= hidx_d;
            sav_dtype_q <= sav_dtype_d;
            pend_q      <= pend_d;
            ev_dtype_q  <= ev_dtype_d;
            ev_meta_q   <= ev_meta_d;
            ev_pix_q    <= ev_pix_d;
            dvo_q       <= dvo_d;
            dtypeo_q    <= dtypeo_d;
            datao_q     <= datao_d;
            ovf_q       <= ovf_d;
        end
    end

    assign dvo      = dvo_q;
    assign dtypeo   = dtypeo_q;
    assign datao    = datao_q;
    assign busy     = pend_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_pix_stream_packer.sv
module tb_pix_stream_packer;

    localparam logic [3:0] PX  = 4'h8;
    localparam logic [3:0] PX9 = 4'h9;
    localparam logic [3:0] FS  = 4'h1;
    localparam logic [3:0] FE  = 4'h2;
    localparam logic [3:0] HS  = 4'h3;
    localparam logic [3:0] HD  = 4'h4;
    localparam logic [3:0] OT  = 4'h5;

    logic        clk;
    logic        resetb;
    logic [15:0] image_type;

    logic        dvi0, dvo0, busy0, ovf0;
    logic [3:0]  dtypei0, dtypeo0;
    logic [15:0] meta0;
    logic [29:0] pix0;
    logic [31:0] datao0;

    logic        dvi1, dvo1, busy1, ovf1;
    logic [3:0]  dtypei1, dtypeo1;
    logic [15:0] meta1;
    logic [29:0] pix1;
    logic [63:0] datao1;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [63:0] dat;
        logic [3:0]  dt;
        logic        bsy;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    pix_stream_packer u0 (
        .clk(clk), .resetb(resetb), .image_type(image_type),
        .dvi(dvi0), .dtypei(dtypei0), .meta_datai(meta0), .pix(pix0),
        .dvo(dvo0), .dtypeo(dtypeo0), .datao(datao0), .busy(busy0), .overflow(ovf0)
    );

    pix_stream_packer #(.OUT_WIDTH(64)) u1 (
        .clk(clk), .resetb(resetb), .image_type(image_type),
        .dvi(dvi1), .dtypei(dtypei1), .meta_datai(meta1), .pix(pix1),
        .dvo(dvo1), .dtypeo(dtypeo1), .datao(datao1), .busy(busy1), .overflow(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor for the 32-bit instance
    always @(negedge clk) begin : mon0
        exp_t e;
        if (resetb && dvo0) begin
            tests++;
            if (q0.size() == 0) begin
                fails++;
                $display("FAIL u0_unexpected_word got dat=%h dt=%h busy=%b", datao0, dtypeo0, busy0);
            end else begin
                e = q0.pop_front();
                if (datao0 !== e.dat[31:0] || dtypeo0 !== e.dt || busy0 !== e.bsy) begin
                    fails++;
                    $display("FAIL u0_word got dat=%h dt=%h busy=%b exp dat=%h dt=%h busy=%b",
                             datao0, dtypeo0, busy0, e.dat[31:0], e.dt, e.bsy);
                end
            end
        end
    end

    // Monitor for the 64-bit instance
    always @(negedge clk) begin : mon1
        exp_t e;
        if (resetb && dvo1) begin
            tests++;
            if (q1.size() == 0) begin
                fails++;
                $display("FAIL u1_unexpected_word got dat=%h dt=%h busy=%b", datao1, dtypeo1, busy1);
            end else begin
                e = q1.pop_front();
                if (datao1 !== e.dat || dtypeo1 !== e.dt || busy1 !== e.bsy) begin
                    fails++;
                    $display("FAIL u1_word got dat=%h dt=%h busy=%b exp dat=%h dt=%h busy=%b",
                             datao1, dtypeo1, busy1, e.dat, e.dt, e.bsy);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic drv0(input logic v, input logic [3:0] dt, input logic [15:0] m, input logic [29:0] p);
        @(negedge clk);
        dvi0 = v; dtypei0 = dt; meta0 = m; pix0 = p;
    endtask

    task automatic drv1(input logic v, input logic [3:0] dt, input logic [15:0] m, input logic [29:0] p);
        @(negedge clk);
        dvi1 = v; dtypei1 = dt; meta1 = m; pix1 = p;
    endtask

    task automatic exp0(input logic [63:0] d, input logic [3:0] dt, input logic b);
        q0.push_back({d, dt, b});
    endtask

    task automatic exp1(input logic [63:0] d, input logic [3:0] dt, input logic b);
        q1.push_back({d, dt, b});
    endtask

    task automatic idle0(input int n);
        for (int i = 0; i < n; i++) drv0(1'b0, 4'h0, 16'h0, 30'h0);
    endtask

    initial begin
        resetb = 1'b1; image_type = 16'h0;
        dvi0 = 0; dtypei0 = 0; meta0 = 0; pix0 = 0;
        dvi1 = 0; dtypei1 = 0; meta1 = 0; pix1 = 0;
        #1 resetb = 1'b0;
        #2;
        chk("rst_dvo", {63'h0, dvo0}, 64'h0);
        chk("rst_datao", {32'h0, datao0}, 64'h0);
        chk("rst_dtypeo", {60'h0, dtypeo0}, 64'h0);
        chk("rst_busy", {63'h0, busy0}, 64'h0);
        chk("rst_overflow", {63'h0, ovf0}, 64'h0);
        chk("rst_u1_datao", datao1, 64'h0);
        @(negedge clk) resetb = 1'b1;

        // Colour packing across a word boundary, then a padded flush at frame end
        image_type = 16'h0001;
        drv0(1, FS, 16'h0, 30'h0);         exp0(64'h0, FS, 0);
        drv0(1, PX9, 16'h0, 30'h3FFFFFFF);
        drv0(1, PX9, 16'h0, 30'h00000002); exp0(64'hBFFFFFFF, PX9, 0);
        drv0(1, PX, 16'h0, 30'h0000003F);  exp0(64'hF0000000, PX, 0);
        drv0(1, FE, 16'h0, 30'h0);         exp0(64'h00000003, PX, 1); exp0(64'h0, FE, 0);
        idle0(3);

        // Raw packing with flush, then pass-through markers
        image_type = 16'h0000;
        drv0(1, FS, 16'h0, 30'h0);         exp0(64'h0, FS, 0);
        drv0(1, PX, 16'h001, 30'h0);
        drv0(1, PX, 16'h002, 30'h0);
        drv0(1, PX, 16'h003, 30'h0);
        drv0(1, FE, 16'h0, 30'h0);         exp0(64'h00300801, PX, 1); exp0(64'h0, FE, 0);
        idle0(2);
        drv0(1, OT, 16'h0, 30'h0);         exp0(64'h0, OT, 0);
        drv0(1, FE, 16'h0, 30'h0);         exp0(64'h0, FE, 0);
        idle0(2);

        // Header packing, image type substitution, and a padded header flush
        image_type = 16'h0005;
        drv0(1, HS, 16'h0, 30'h0);         exp0(64'h0, HS, 0);
        drv0(1, HD, 16'h1111, 30'h0);
        drv0(1, HD, 16'h2222, 30'h0);      exp0(64'h22221111, HD, 0);
        drv0(1, HD, 16'hAAAA, 30'h0);
        drv0(1, HD, 16'hBBBB, 30'h0);      exp0(64'hBBBB0005, HD, 0);
        drv0(1, HD, 16'hCCCC, 30'h0);
        drv0(1, FE, 16'h0, 30'h0);         exp0(64'h0000CCCC, HD, 1); exp0(64'h0, FE, 0);
        idle0(3);

        // Input during busy is dropped and sets overflow; frame start clears it
        image_type = 16'h0001;
        drv0(1, FS, 16'h0, 30'h0);         exp0(64'h0, FS, 0);
        drv0(1, PX, 16'h0, 30'h00000155);
        drv0(1, FE, 16'h0, 30'h0);         exp0(64'h00000155, PX, 1); exp0(64'h0, FE, 0);
        drv0(1, PX, 16'h0, 30'h3FFFFFFF);
        idle0(1);
        chk("ovf_set", {63'h0, ovf0}, 64'h1);
        idle0(1);
        chk("ovf_sticky", {63'h0, ovf0}, 64'h1);
        drv0(1, FS, 16'h0, 30'h0);         exp0(64'h0, FS, 0);
        idle0(1);
        chk("ovf_clear", {63'h0, ovf0}, 64'h0);
        drv0(1, PX, 16'h0, 30'h12345678);
        drv0(1, PX, 16'h0, 30'h00000001);  exp0(64'h52345678, PX, 0);
        drv0(1, FS, 16'h0, 30'h0);         exp0(64'h0, FS, 0);
        idle0(2);

        // Reset asserted during the flush cycle discards the held frame end
        image_type = 16'h0000;
        drv0(1, FS, 16'h0, 30'h0);         exp0(64'h0, FS, 0);
        drv0(1, PX, 16'h03FF, 30'h0);
        drv0(1, FE, 16'h0, 30'h0);         exp0(64'h000003FF, PX, 1);
        drv0(0, 4'h0, 16'h0, 30'h0);
        chk("busy_before_rst", {63'h0, busy0}, 64'h1);
        #1 resetb = 1'b0;
        #1;
        chk("midrst_dvo", {63'h0, dvo0}, 64'h0);
        chk("midrst_datao", {32'h0, datao0}, 64'h0);
        chk("midrst_dtypeo", {60'h0, dtypeo0}, 64'h0);
        chk("midrst_busy", {63'h0, busy0}, 64'h0);
        @(negedge clk) resetb = 1'b1;
        image_type = 16'h0001;
        drv0(1, PX, 16'h0, 30'h12345678);
        drv0(1, PX, 16'h0, 30'h00000001);  exp0(64'h52345678, PX, 0);
        drv0(1, FS, 16'h0, 30'h0);         exp0(64'h0, FS, 0);
        idle0(2);

        // 64-bit instance: three pixels fill one word, frame start drops the residual
        image_type = 16'h0007;
        drv1(1, FS, 16'h0, 30'h0);         exp1(64'h0, FS, 0);
        drv1(1, PX, 16'h0, 30'h3FFFFFFF);
        drv1(1, PX, 16'h0, 30'h00000001);
        drv1(1, PX, 16'h0, 30'h3FFFFFF5);  exp1(64'h500000007FFFFFFF, PX, 0);
        drv1(1, FS, 16'h0, 30'h0);         exp1(64'h0, FS, 0);
        drv1(1, PX, 16'h0, 30'h3FFFFFFF);
        drv1(1, PX, 16'h0, 30'h3FFFFFFF);
        drv1(1, PX, 16'h0, 30'h00000000);  exp1(64'h0FFFFFFFFFFFFFFF, PX, 0);
        drv1(1, HS, 16'h0, 30'h0);         exp1(64'h0, HS, 0);
        drv1(1, HD, 16'h0001, 30'h0);
        drv1(1, HD, 16'h0002, 30'h0);
        drv1(1, HD, 16'h0003, 30'h0);
        drv1(1, HD, 16'h0004, 30'h0);      exp1(64'h0004000700020001, HD, 0);
        drv1(0, 4'h0, 16'h0, 30'h0);
        chk("u1_busy_idle", {63'h0, busy1}, 64'h0);
        repeat (4) @(negedge clk);

        chk("u0_queue_drained", 64'(q0.size()), 64'h0);
        chk("u1_queue_drained", 64'(q1.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
